// File: rtl/ex_wb_buffer.sv
// EX->WB result buffer: 2-entry in-order FIFO with op filter and retire count.
// Define EX_WB_FORWARD_EN to build the forwarding lookup.
package ex_wb_pkg;
   typedef struct packed {
      logic [3:0]  rd;
      logic [16:0] data;
   } wb_entry_t;
endpackage

module ex_wb_buffer
   import ex_wb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_opcode,
   input  logic [3:0]  in_rd,
   input  logic [16:0] in_result,
   input  logic        in_cond_met,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [3:0]  wb_rd,
   output logic [16:0] wb_data,
   output logic [15:0] retire_cnt,
   input  logic [3:0]  q_rs1,
   input  logic [3:0]  q_rs2,
   output logic        fwd1_hit,
   output logic        fwd2_hit,
   output logic [16:0] fwd1_data,
   output logic [16:0] fwd2_data
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0] state, state_nx;
   wb_entry_t  head, tail, head_nx, tail_nx, new_e;
   logic       accept, pop;
   logic       is_mem, is_cond;
   logic       do_enq, do_cnt;

   assign in_ready = (state != S_FULL);
   assign wb_valid = (state != S_EMPTY);
   assign wb_rd    = head.rd;
   assign wb_data  = head.data;

   assign accept = in_valid & in_ready;
   assign pop    = wb_valid & wb_ready;

   always_comb begin
      is_mem  = 1'b0;
      is_cond = 1'b0;
      unique case (1'b1)
         (in_opcode[3:1] == 3'b110): is_mem  = 1'b1;
         (in_opcode[3:1] == 3'b111): is_cond = 1'b1;
         default: ;
      endcase
   end

   // Dropped CAIZ/CAIF still retire; loads/stores retire elsewhere.
   assign do_cnt = accept & ~is_mem;
   assign do_enq = do_cnt & (~is_cond | in_cond_met);

   assign new_e.rd   = in_rd;
   assign new_e.data = in_result;

   always_comb begin
      state_nx = state;
      head_nx  = head;
      tail_nx  = tail;
      unique case (state)
         S_EMPTY: begin
            if (do_enq) begin
               head_nx  = new_e;
               state_nx = S_ONE;
            end
         end
         S_ONE: begin
            if (do_enq && pop) begin
               head_nx = new_e;
            end else if (do_enq) begin
               tail_nx  = new_e;
               state_nx = S_FULL;
            end else if (pop) begin
               state_nx = S_EMPTY;
            end
         end
         S_FULL: begin
            if (pop) begin
               head_nx  = tail;
               state_nx = S_ONE;
            end
         end
         default: state_nx = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_EMPTY;
         head       <= '0;
         tail       <= '0;
         retire_cnt <= '0;
      end else begin
         state <= state_nx;
         head  <= head_nx;
         tail  <= tail_nx;
         if (do_cnt)
            retire_cnt <= retire_cnt + 16'd1;
      end
   end

`ifdef EX_WB_FORWARD_EN
   logic h_v, t_v;

   assign h_v = (state != S_EMPTY);
   assign t_v = (state == S_FULL);

   // Tail is the younger entry, so it wins when both match.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      if (t_v && tail.rd == q_rs1) begin
         fwd1_hit  = 1'b1;
         fwd1_data = tail.data;
      end else if (h_v && head.rd == q_rs1) begin
         fwd1_hit  = 1'b1;
         fwd1_data = head.data;
      end
   end

   always_comb begin
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      if (t_v && tail.rd == q_rs2) begin
         fwd2_hit  = 1'b1;
         fwd2_data = tail.data;
      end else if (h_v && head.rd == q_rs2) begin
         fwd2_hit  = 1'b1;
         fwd2_data = head.data;
      end
   end
`else
   logic unused_q;

   assign unused_q  = ^{q_rs1, q_rs2};
   assign fwd1_hit  = 1'b0;
   assign fwd2_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Directed bench for ex_wb_buffer: filter, ordering, backpressure,
// forwarding, async reset and retire counter wrap.
module tb_ex_wb_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [3:0]  in_rd;
   logic [16:0] in_result;
   logic        in_cond_met;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_rd;
   logic [16:0] wb_data;
   logic [15:0] retire_cnt;
   logic [3:0]  q_rs1, q_rs2;
   logic        fwd1_hit, fwd2_hit;
   logic [16:0] fwd1_data, fwd2_data;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ex_wb_buffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_result  (in_result),
      .in_cond_met(in_cond_met),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .retire_cnt (retire_cnt),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .fwd1_hit   (fwd1_hit),
      .fwd2_hit   (fwd2_hit),
      .fwd1_data  (fwd1_data),
      .fwd2_data  (fwd2_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [3:0] op,
                        input logic [3:0] rd, input logic [16:0] res,
                        input logic cm);
      in_valid    = v;
      in_opcode   = op;
      in_rd       = rd;
      in_result   = res;
      in_cond_met = cm;
   endtask

   initial begin
      rst_n    = 1'b0;
      wb_ready = 1'b1;
      q_rs1    = 4'd0;
      q_rs2    = 4'd0;
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      #1;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_retire", 32'(retire_cnt), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_fwd1", 32'({fwd1_hit, fwd1_data}), 32'd0);
      chk("rst_fwd2", 32'({fwd2_hit, fwd2_data}), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      // ADD rd=3
      drive(1'b1, 4'h0, 4'd3, 17'h01234, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("add_wb_valid", 32'(wb_valid), 32'd1);
      chk("add_wb_rd", 32'(wb_rd), 32'd3);
      chk("add_wb_data", 32'(wb_data), 32'h01234);
      chk("add_retire", 32'(retire_cnt), 32'd1);
      @(negedge clk);
      chk("add_drained", 32'(wb_valid), 32'd0);

      // CAIF not taken: dropped but retired
      drive(1'b1, 4'hF, 4'd5, 17'h0AAAA, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("caif_no_wb", 32'(wb_valid), 32'd0);
      chk("caif_retire", 32'(retire_cnt), 32'd2);
      // CAIZ taken
      drive(1'b1, 4'hE, 4'd6, 17'h00007, 1'b1);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("caiz_wb_valid", 32'(wb_valid), 32'd1);
      chk("caiz_wb_rd", 32'(wb_rd), 32'd6);
      chk("caiz_wb_data", 32'(wb_data), 32'h7);
      chk("caiz_retire", 32'(retire_cnt), 32'd3);
      @(negedge clk);
      chk("caiz_drained", 32'(wb_valid), 32'd0);

      // Backpressure: fill with A, B; C held upstream
      wb_ready = 1'b0;
      drive(1'b1, 4'h1, 4'd1, 17'h00011, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'h2, 4'd2, 17'h00022, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'h3, 4'd7, 17'h00033, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_wb_valid", 32'(wb_valid), 32'd1);
      chk("full_head_rd", 32'(wb_rd), 32'd1);
      @(negedge clk);
      chk("stall_rd", 32'(wb_rd), 32'd1);
      chk("stall_data", 32'(wb_data), 32'h00011);
      chk("stall_retire", 32'(retire_cnt), 32'd5);
      wb_ready = 1'b1;
      @(negedge clk);
      chk("pop_a_rd", 32'(wb_rd), 32'd2);
      chk("pop_a_data", 32'(wb_data), 32'h00022);
      chk("pop_a_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("c_rd", 32'(wb_rd), 32'd7);
      chk("c_data", 32'(wb_data), 32'h00033);
      chk("c_retire", 32'(retire_cnt), 32'd6);
      @(negedge clk);
      chk("c_drained", 32'(wb_valid), 32'd0);

      // Two entries for rd=4; younger must be forwarded
      wb_ready = 1'b0;
      drive(1'b1, 4'h0, 4'd4, 17'h10010, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'h0, 4'd4, 17'h00020, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      q_rs1 = 4'd4;
      q_rs2 = 4'd9;
      #1;
`ifdef EX_WB_FORWARD_EN
      chk("fwd1_hit", 32'(fwd1_hit), 32'd1);
      chk("fwd1_data", 32'(fwd1_data), 32'h00020);
      q_rs1 = 4'd4;
`else
      chk("fwd1_hit_off", 32'(fwd1_hit), 32'd0);
      chk("fwd1_data_off", 32'(fwd1_data), 32'd0);
`endif
      chk("fwd2_hit", 32'(fwd2_hit), 32'd0);
      chk("fwd2_data", 32'(fwd2_data), 32'd0);
      chk("fwd_retire", 32'(retire_cnt), 32'd8);

      // Async reset while FULL
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_wb_valid", 32'(wb_valid), 32'd0);
      chk("arst_retire", 32'(retire_cnt), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_wb_data", 32'(wb_data), 32'd0);
      drive(1'b1, 4'h0, 4'd8, 17'h00088, 1'b0);
      wb_ready = 1'b1;
      @(negedge clk);
      chk("rst_ignore_valid", 32'(wb_valid), 32'd0);
      chk("rst_ignore_cnt", 32'(retire_cnt), 32'd0);
      rst_n = 1'b1;
      drive(1'b1, 4'hC, 4'd9, 17'h00099, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("load_no_wb", 32'(wb_valid), 32'd0);
      chk("load_retire", 32'(retire_cnt), 32'd0);

      // Back-to-back stream at full rate
      drive(1'b1, 4'h5, 4'd10, 17'h00100, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'h6, 4'd11, 17'h00200, 1'b0);
      chk("s1_rd", 32'(wb_rd), 32'd10);
      chk("s1_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b1, 4'h7, 4'd12, 17'h00300, 1'b0);
      chk("s2_rd", 32'(wb_rd), 32'd11);
      chk("s2_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("s3_data", 32'(wb_data), 32'h00300);
      chk("s3_retire", 32'(retire_cnt), 32'd3);
      @(negedge clk);
      chk("s_drained", 32'(wb_valid), 32'd0);

      // Counter wrap
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 4'h0, 4'd1, 17'h00001, 1'b0);
      repeat (65535) @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("cnt_ffff", 32'(retire_cnt), 32'h0000FFFF);
      drive(1'b1, 4'h0, 4'd1, 17'h00001, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'd0, 17'h0, 1'b0);
      chk("cnt_wrap", 32'(retire_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
